// File: rtl/cpu_debug_pkg.sv
// Shared types for the commit-trace path: one trace record and the
// write-enable pattern driven on the debug pins.
package cpu_debug_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } trace_rec_t;

  localparam logic [3:0] DEBUG_WEN_ALL = 4'hf;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Ordered dual-push / single-pop FIFO. Requests are compacted so the
// older request lands at wr_ptr. Pushes are admitted against the
// pre-edge free space only; a same-cycle pop never makes room.
module trace_fifo_2w1r
  import cpu_debug_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = trace_rec_t
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req0,
  input  T                         d0,
  input  logic                     req1,
  input  T                         d1,
  input  logic                     pop_req,
  output T                         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               acc_cnt,
  output logic                     drop
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  T            mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, free, n_req_w;
  logic [1:0]  n_req;
  logic [AW-1:0] wa0, wa1;
  logic        pop;
  T            first;

  // Pointers carry one extra wrap bit, so the difference is the fill level.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign free    = DEPTH_W - count;
  assign n_req   = {1'b0, req0} + {1'b0, req1};
  assign n_req_w = {{(AW-1){1'b0}}, n_req};
  // free < n_req only when free is 0 or 1, so its low bits are the grant.
  assign acc_cnt = (free >= n_req_w) ? n_req : free[1:0];
  assign drop    = (n_req != acc_cnt);
  assign first   = req0 ? d0 : d1;
  assign pop     = pop_req && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign wa0     = wr_ptr[AW-1:0];
  assign wa1     = wr_ptr[AW-1:0] + AW'(1);

  // Pointer advance: writes by the accepted count, reads by one on pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, acc_cnt};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
    end
  end

  // Storage write; second slot only used when both requests are granted.
  always_ff @(posedge clk) begin
    if (acc_cnt != 2'd0) mem[wa0] <= first;
    if (acc_cnt == 2'd2) mem[wa1] <= d1;
  end

endmodule

// File: rtl/commit_trace_serializer.sv
// Merges the two write-back channels into one ordered commit-trace
// stream in the single-port debug format. Field outputs read as zero
// while the queue is empty so idle cycles are visible as pc == 0.
module commit_trace_serializer
  import cpu_debug_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit FILTER_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb0_en,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_wdata,
  input  logic [31:0] wb0_pc,
  input  logic        wb1_en,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_wdata,
  input  logic [31:0] wb1_pc,
  input  logic        out_ready,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        overflow,
  output logic [31:0] commit_cnt
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] RDY_MAX = (AW+1)'(DEPTH - 2);

  trace_rec_t  rec0, rec1, head;
  logic        q0, q1, empty, drop;
  logic [1:0]  acc_cnt;
  logic [AW:0] count;

  // A slot qualifies on its enable, optionally ignoring writes to x0.
  assign q0   = wb0_en && (!FILTER_R0 || (wb0_rd != 5'd0));
  assign q1   = wb1_en && (!FILTER_R0 || (wb1_rd != 5'd0));
  assign rec0 = '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata};
  assign rec1 = '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata};

  trace_fifo_2w1r #(.DEPTH(DEPTH), .T(trace_rec_t)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .req0    (q0),
    .d0      (rec0),
    .req1    (q1),
    .d1      (rec1),
    .pop_req (out_ready),
    .head    (head),
    .empty   (empty),
    .count   (count),
    .acc_cnt (acc_cnt),
    .drop    (drop)
  );

  assign out_valid         = !empty;
  assign in_ready          = (count <= RDY_MAX);
  assign debug_wb_pc       = out_valid ? head.pc    : 32'h0;
  assign debug_wb_rf_wnum  = out_valid ? head.rd    : 5'h0;
  assign debug_wb_rf_wdata = out_valid ? head.wdata : 32'h0;
  assign debug_wb_rf_wen   = out_valid ? DEBUG_WEN_ALL : 4'h0;

  // Sticky drop flag and running count of accepted records.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow   <= 1'b0;
      commit_cnt <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      commit_cnt <= commit_cnt + {30'd0, acc_cnt};
    end
  end

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Randomized + directed bench with a queue-based reference model and a
// negedge monitor comparing every visible output against it.
module tb_commit_trace_serializer;
  import cpu_debug_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb0_en, wb1_en, out_ready;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_wdata, wb0_pc, wb1_wdata, wb1_pc;
  logic        in_ready, out_valid, overflow;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata, commit_cnt;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  // second build with the x0 filter disabled
  logic        nf_in_ready, nf_out_valid, nf_overflow;
  logic [31:0] nf_pc, nf_wdata, nf_commit_cnt;
  logic [3:0]  nf_wen;
  logic [4:0]  nf_wnum;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  commit_trace_serializer #(.DEPTH(DEPTH), .FILTER_R0(1'b1)) u_dut (
    .clk(clk), .resetn(resetn),
    .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_wdata(wb0_wdata), .wb0_pc(wb0_pc),
    .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_wdata(wb1_wdata), .wb1_pc(wb1_pc),
    .out_ready(out_ready), .in_ready(in_ready), .out_valid(out_valid),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .overflow(overflow), .commit_cnt(commit_cnt)
  );

  commit_trace_serializer #(.DEPTH(DEPTH), .FILTER_R0(1'b0)) u_nf (
    .clk(clk), .resetn(resetn),
    .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_wdata(wb0_wdata), .wb0_pc(wb0_pc),
    .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_wdata(wb1_wdata), .wb1_pc(wb1_pc),
    .out_ready(out_ready), .in_ready(nf_in_ready), .out_valid(nf_out_valid),
    .debug_wb_pc(nf_pc), .debug_wb_rf_wen(nf_wen),
    .debug_wb_rf_wnum(nf_wnum), .debug_wb_rf_wdata(nf_wdata),
    .overflow(nf_overflow), .commit_cnt(nf_commit_cnt)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  trace_rec_t  mq[$];
  trace_rec_t  cand[$];
  logic        m_ovf;
  logic [31:0] m_cnt;
  int          m_free;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = 32'd0;
    end else begin
      m_free = DEPTH - mq.size();
      cand.delete();
      if (wb0_en && wb0_rd != 5'd0) cand.push_back('{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata});
      if (wb1_en && wb1_rd != 5'd0) cand.push_back('{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata});
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      foreach (cand[i]) begin
        if (m_free > 0) begin
          mq.push_back(cand[i]);
          m_free--;
          m_cnt++;
        end else m_ovf = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [73:0] exp_head;
  always @(negedge clk) begin
    if (mq.size() > 0) exp_head = {1'b1, 4'hf, mq[0].pc, mq[0].rd, mq[0].wdata};
    else               exp_head = '0;
    chk("head", {22'd0, out_valid, debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata},
        {22'd0, exp_head});
    chk("status", {62'd0, overflow, in_ready, commit_cnt},
        {62'd0, m_ovf, (mq.size() <= DEPTH - 2), m_cnt});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e0, input logic [31:0] p0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic e1, input logic [31:0] p1, input logic [4:0] r1, input logic [31:0] d1);
    wb0_en = e0; wb0_pc = p0; wb0_rd = r0; wb0_wdata = d0;
    wb1_en = e1; wb1_pc = p1; wb1_rd = r1; wb1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 5'h0, 32'h0, 1'b0, 32'h0, 5'h0, 32'h0);
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    idle();
    out_ready = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    out_ready = 1'b0;
    idle();
    step();
    step();
    resetn = 1'b1;

    // 1: idle after reset
    repeat (10) step();
    chk("idle_valid", {95'd0, out_valid}, 96'd0);
    chk("idle_pc", {64'd0, debug_wb_pc}, 96'd0);
    chk("idle_wen", {92'd0, debug_wb_rf_wen}, 96'd0);
    chk("idle_rdy", {95'd0, in_ready}, 96'd1);
    chk("idle_cnt", {64'd0, commit_cnt}, 96'd0);

    // 2: dual push drained immediately
    out_ready = 1'b1;
    drive(1'b1, 32'hbfc00000, 5'd3, 32'd1, 1'b1, 32'hbfc00004, 5'd4, 32'd2);
    step();
    idle();
    chk("dual_pc0", {64'd0, debug_wb_pc}, {64'd0, 32'hbfc00000});
    chk("dual_rd0", {91'd0, debug_wb_rf_wnum}, 96'd3);
    chk("dual_wen", {92'd0, debug_wb_rf_wen}, 96'hf);
    step();
    chk("dual_pc1", {64'd0, debug_wb_pc}, {64'd0, 32'hbfc00004});
    chk("dual_rd1", {91'd0, debug_wb_rf_wnum}, 96'd4);
    step();
    chk("dual_empty", {95'd0, out_valid}, 96'd0);
    chk("dual_cnt", {64'd0, commit_cnt}, 96'd2);

    // 3: x0 filter, and the unfiltered build emits both
    drive(1'b1, 32'hbfc0000c, 5'd0, 32'd7, 1'b1, 32'hbfc00010, 5'd5, 32'hdeadbeef);
    step();
    idle();
    chk("r0_pc", {64'd0, debug_wb_pc}, {64'd0, 32'hbfc00010});
    chk("r0_data", {64'd0, debug_wb_rf_wdata}, {64'd0, 32'hdeadbeef});
    chk("r0_cnt", {64'd0, commit_cnt}, 96'd3);
    chk("nf_pc0", {59'd0, nf_wnum, nf_pc}, {59'd0, 5'd0, 32'hbfc0000c});
    step();
    chk("r0_empty", {95'd0, out_valid}, 96'd0);
    chk("nf_pc1", {59'd0, nf_wnum, nf_pc}, {59'd0, 5'd5, 32'hbfc00010});
    step();

    // 4: fill under backpressure, then overflow, then ordered drain
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h1000 + 8*c, 5'd1 + 5'(c), 32'hA0 + c, 1'b1, 32'h1004 + 8*c, 5'd9 + 5'(c), 32'hB0 + c);
      step();
      if (c == 3) begin
        chk("full_rdy", {95'd0, in_ready}, 96'd0);
        chk("full_ovf", {95'd0, overflow}, 96'd0);
      end
    end
    idle();
    chk("full_ovf5", {95'd0, overflow}, 96'd1);
    chk("full_cnt", {64'd0, commit_cnt}, 96'd11);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_pc", {64'd0, debug_wb_pc}, {64'd0, 32'h1000 + 4*k});
      step();
    end
    chk("drain_empty", {95'd0, out_valid}, 96'd0);

    // 5: partial fit with a concurrent pop
    do_reset();
    chk("rst_ovf", {95'd0, overflow}, 96'd0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h3000 + 8*c, 5'd2, 32'hC0 + c, 1'b1, 32'h3004 + 8*c, 5'd6, 32'hD0 + c);
      step();
    end
    drive(1'b1, 32'h3018, 5'd7, 32'hE0, 1'b0, 32'h0, 5'd0, 32'h0);
    step();
    out_ready = 1'b1;
    drive(1'b1, 32'h3100, 5'd8, 32'hF0, 1'b1, 32'h3104, 5'd10, 32'hF1);
    step();
    idle();
    chk("part_ovf", {95'd0, overflow}, 96'd1);
    chk("part_rdy", {95'd0, in_ready}, 96'd0);
    chk("part_head", {64'd0, debug_wb_pc}, {64'd0, 32'h3004});
    chk("part_cnt", {64'd0, commit_cnt}, 96'd8);
    repeat (8) step();
    chk("part_empty", {95'd0, out_valid}, 96'd0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
            $urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // 6: async reset with records queued
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h5000, 5'd1, 32'h1, 1'b1, 32'h5004, 5'd2, 32'h2);
    step();
    drive(1'b1, 32'h5008, 5'd3, 32'h3, 1'b1, 32'h500c, 5'd4, 32'h4);
    step();
    drive(1'b1, 32'h5010, 5'd5, 32'h5, 1'b0, 32'h0, 5'd0, 32'h0);
    step();
    idle();
    chk("pre_rst_cnt", {64'd0, commit_cnt}, 96'd5);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out", {22'd0, out_valid, debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata}, 96'd0);
    chk("arst_stat", {62'd0, overflow, in_ready, commit_cnt}, {62'd0, 1'b0, 1'b1, 32'd0});
    step();
    resetn = 1'b1;
    drive(1'b1, 32'h6000, 5'd12, 32'h66, 1'b0, 32'h0, 5'd0, 32'h0);
    step();
    idle();
    chk("post_pc", {64'd0, debug_wb_pc}, {64'd0, 32'h6000});
    chk("post_cnt", {64'd0, commit_cnt}, 96'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
